// File: rtl/voice_mixer.sv
// voice_mixer: serial one-voice-per-clock summing mixer.
// Snapshot on tick, accumulate, shift, saturate, pulse valid.
module voice_mixer #(
  parameter int BITDEPTH = 14,
  parameter int NVOICES  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_tick,
  input  logic [NVOICES*BITDEPTH-1:0] voices,
  input  logic [NVOICES-1:0]          voice_en,
  input  logic [2:0]                  atten,
  input  logic                        clear_overrun,
  output logic [BITDEPTH-1:0]         out,
  output logic                        out_valid,
  output logic                        clip,
  output logic                        busy,
  output logic                        overrun
);

  localparam int ACCWIDTH = BITDEPTH + $clog2(NVOICES) + 1;
  localparam int IDXW     = $clog2(NVOICES);
  localparam int EXTW     = ACCWIDTH - BITDEPTH;

  localparam logic [IDXW-1:0] LAST = IDXW'(NVOICES - 1);

  localparam logic signed [ACCWIDTH-1:0] SMAX =
    ACCWIDTH'((1 << (BITDEPTH - 1)) - 1);
  localparam logic signed [ACCWIDTH-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE
  } state_t;

  state_t state_q, state_d;

  logic signed [ACCWIDTH-1:0] acc_q, acc_d;
  logic [IDXW-1:0]            idx_q, idx_d;

  logic [NVOICES*BITDEPTH-1:0] vs_q, vs_d;
  logic [NVOICES-1:0]          en_q, en_d;
  logic [2:0]                  at_q, at_d;

  logic [BITDEPTH-1:0] out_q, out_d;
  logic                valid_q, valid_d;
  logic                clip_q, clip_d;
  logic                busy_q, busy_d;
  logic                ovr_q, ovr_d;

  logic signed [BITDEPTH-1:0] cur_v;
  logic signed [ACCWIDTH-1:0] cur_ext;
  logic signed [ACCWIDTH-1:0] shifted;

  assign cur_v   = vs_q[idx_q*BITDEPTH +: BITDEPTH];
  assign cur_ext = {{EXTW{cur_v[BITDEPTH-1]}}, cur_v};
  assign shifted = acc_q >>> at_q;

  // Next-state logic for the mix sequencer and its datapath.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    vs_d    = vs_q;
    en_d    = en_q;
    at_d    = at_q;
    out_d   = out_q;
    valid_d = 1'b0;
    clip_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          vs_d    = voices;
          en_d    = voice_en;
          at_d    = atten;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (en_q[idx_q]) begin
          acc_d = acc_q + cur_ext;
        end
        idx_d = idx_q + IDXW'(1);
        if (idx_q == LAST) begin
          state_d = SCALE;
        end
      end
      SCALE: begin
        if (shifted > SMAX) begin
          out_d  = SMAX[BITDEPTH-1:0];
          clip_d = 1'b1;
        end else if (shifted < SMIN) begin
          out_d  = SMIN[BITDEPTH-1:0];
          clip_d = 1'b1;
        end else begin
          out_d  = shifted[BITDEPTH-1:0];
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sticky overrun: a tick while busy sets, clear wins only alone.
  always_comb begin
    ovr_d = ovr_q;
    if (sample_tick && busy_q) begin
      ovr_d = 1'b1;
    end else if (clear_overrun) begin
      ovr_d = 1'b0;
    end
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      vs_q    <= '0;
      en_q    <= '0;
      at_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      vs_q    <= vs_d;
      en_q    <= en_d;
      at_q    <= at_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign clip      = clip_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed and random mixes vs an
// arithmetic reference model of the mixing rules.
module tb_voice_mixer;

  localparam int BD = 14;
  localparam int NV = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sample_tick = 1'b0;
  logic [NV*BD-1:0] voices = '0;
  logic [NV-1:0]    voice_en = '0;
  logic [2:0]       atten = '0;
  logic             clear_overrun = 1'b0;
  logic [BD-1:0]    out;
  logic             out_valid;
  logic             clip;
  logic             busy;
  logic             overrun;

  voice_mixer #(.BITDEPTH(BD), .NVOICES(NV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_tick(sample_tick),
    .voices(voices),
    .voice_en(voice_en),
    .atten(atten),
    .clear_overrun(clear_overrun),
    .out(out),
    .out_valid(out_valid),
    .clip(clip),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int          cur_v[NV];
  logic [NV-1:0] cur_en;
  int          cur_at;
  int          last_out;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: integer sum of enabled voices, shift, clamp.
  function automatic int mix_ref(output int clp);
    int sum;
    int s;
    sum = 0;
    for (int i = 0; i < NV; i++)
      if (cur_en[i]) sum += cur_v[i];
    s = sum >>> cur_at;
    clp = 0;
    if (s > 8191) begin
      s = 8191;
      clp = 1;
    end else if (s < -8192) begin
      s = -8192;
      clp = 1;
    end
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < NV; i++)
      voices[i*BD +: BD] = cur_v[i][BD-1:0];
    voice_en = cur_en;
    atten = 3'(cur_at);
  endtask

  task automatic set_all(input int v, input int at);
    for (int i = 0; i < NV; i++) cur_v[i] = v;
    cur_en = '1;
    cur_at = at;
  endtask

  task automatic set_rand();
    for (int i = 0; i < NV; i++)
      cur_v[i] = int'($urandom_range(16383)) - 8192;
    cur_en = NV'($urandom);
    cur_at = int'($urandom_range(7));
  endtask

  // Starts a mix at this negedge; returns at the out_valid negedge.
  task automatic run_mix(input string tag,
                         input bit scramble,
                         input bit dbl);
    int exp;
    int ec;
    int lat;
    int bcnt;
    bit got;
    exp = mix_ref(ec);
    drive();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    bcnt = busy ? 1 : 0;
    lat = 0;
    got = 0;
    if (scramble) begin
      voice_en = '0;
      voices = ~voices;
      atten = ~atten;
    end
    while (!got && lat < 30) begin
      @(negedge clk);
      lat++;
      if (dbl && lat == 2) begin
        sample_tick = 1'b1;
        clear_overrun = 1'b1;
      end else begin
        sample_tick = 1'b0;
        clear_overrun = 1'b0;
      end
      if (out_valid) got = 1;
      else if (busy) bcnt++;
    end
    chk({tag, " latency"}, lat, NV + 1);
    chk({tag, " busy"}, bcnt, NV + 1);
    chk({tag, " out"}, $signed(out), exp);
    chk({tag, " clip"}, int'(clip), ec);
    last_out = exp;
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    chk({tag, " valid pulse"}, int'(out_valid), 0);
    chk({tag, " clip pulse"}, int'(clip), 0);
    chk({tag, " out hold"}, $signed(out), last_out);
    chk({tag, " idle"}, int'(busy), 0);
  endtask

  task automatic count_valid(input string tag, input int cyc);
    int nv;
    nv = 0;
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk(tag, nv, 0);
  endtask

  initial begin
    last_out = 0;
    #12;
    chk("rst out", $signed(out), 0);
    chk("rst valid", int'(out_valid), 0);
    chk("rst clip", int'(clip), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst overrun", int'(overrun), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_all(1000, 3);
    run_mix("basic", 0, 0);
    settle("basic");

    set_all(8191, 0);
    run_mix("pos sat", 0, 0);
    settle("pos sat");
    set_all(8191, 3);
    run_mix("pos shift", 0, 0);

    set_all(-8192, 0);
    run_mix("neg sat", 0, 0);
    settle("neg sat");

    set_all(5000, 0);
    cur_v[0] = 100;
    cur_v[2] = -300;
    cur_en = 8'h05;
    run_mix("enables", 1, 0);
    settle("enables");

    // Asynchronous reset in the middle of accumulation.
    set_rand();
    drive();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out", $signed(out), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst valid", int'(out_valid), 0);
    count_valid("midrst no valid", 12);
    rst_n = 1'b1;
    last_out = 0;
    @(negedge clk);
    set_rand();
    run_mix("post rst", 0, 0);
    settle("post rst");

    set_rand();
    run_mix("ovr", 0, 1);
    count_valid("ovr single valid", 12);
    chk("ovr sticky", int'(overrun), 1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    chk("ovr cleared", int'(overrun), 0);

    for (int m = 0; m < 16; m++) begin
      set_rand();
      run_mix($sformatf("chain%0d", m), 0, 0);
    end
    settle("chain end");
    chk("chain overrun", int'(overrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_chk, n_err);
    $finish;
  end

endmodule
